// File: rtl/count_report_tx.sv
// Snapshots a counter on request, converts it to decimal ASCII with a sequential
// double-dabble engine and pushes the text frame into the UART TX FIFO.
// Optional leading mode tag ('U'/'D') when COUNT_REPORT_MODE_TAG_EN is defined.
module count_report_tx #(
  parameter int COUNT_W  = 14,
  parameter int DIGITS   = 4,
  parameter int EOL_CRLF = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_req,
  input  logic [COUNT_W-1:0] i_count,
  input  logic               i_mode,
  input  logic               i_fifo_full,
  output logic               o_push,
  output logic [7:0]         o_push_data,
  output logic               o_busy,
  output logic               o_done
);

`ifdef COUNT_REPORT_MODE_TAG_EN
  localparam int TAG_N = 1;
`else
  localparam int TAG_N = 0;
`endif
  localparam int BCD_W   = DIGITS * 4;
  localparam int FRAME_L = DIGITS + ((EOL_CRLF != 0) ? 2 : 1) + TAG_N;
  localparam int IDX_W   = $clog2(FRAME_L);
  localparam int ITER_W  = $clog2(COUNT_W + 1);
  localparam logic [COUNT_W-1:0] CLAMP_V = COUNT_W'(10**DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_SEND = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [COUNT_W-1:0]  r_bin;
  logic [BCD_W-1:0]    r_bcd;
  logic [BCD_W-1:0]    w_bcd_adj;
  logic [ITER_W-1:0]   r_iter;
  logic [IDX_W-1:0]    r_idx;
  logic                r_done;
  logic                w_push;
  logic                w_last;
  logic                w_conv_end;
  logic [7:0]          w_data;

  // FIFO handshake: a byte transfers on every rising edge where o_push=1;
  // o_push is simply "byte available" qualified by !i_fifo_full, and
  // o_push_data stays stable until that byte has transferred.
  assign w_push     = (r_state == S_SEND) && !i_fifo_full;
  assign w_last     = w_push && (r_idx == IDX_W'(FRAME_L - 1));
  assign w_conv_end = (r_state == S_CONV) && (r_iter == ITER_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_req)      w_next = S_CONV;
      S_CONV:  if (w_conv_end) w_next = S_SEND;
      S_SEND:  if (w_last)     w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Add-3 correction applied to each nibble ahead of the shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_bcd[d*4 +: 4] >= 4'd5) w_bcd_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_iter <= '0;
      r_idx  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      case (r_state)
        S_IDLE: begin
          if (i_req) begin
            r_bin  <= (i_count > CLAMP_V) ? CLAMP_V : i_count;
            r_bcd  <= '0;
            r_iter <= ITER_W'(COUNT_W);
            r_idx  <= '0;
          end
        end
        S_CONV: begin
          r_bcd  <= {w_bcd_adj[BCD_W-2:0], r_bin[COUNT_W-1]};
          r_bin  <= {r_bin[COUNT_W-2:0], 1'b0};
          r_iter <= r_iter - ITER_W'(1);
        end
        S_SEND: begin
          if (w_push) r_idx <= r_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef COUNT_REPORT_MODE_TAG_EN
  logic r_mode;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         r_mode <= 1'b0;
    else if (r_state == S_IDLE && i_req) r_mode <= i_mode;
  end
`else
  logic w_unused_mode;
  assign w_unused_mode = i_mode;
`endif

  // Byte selection: [tag], digits MSD first, then CR (optional) and LF.
  always_comb begin
    w_data = 8'h00;
    if (r_state == S_SEND) begin
      w_data = 8'h0A;
      if ((EOL_CRLF != 0) && (r_idx == IDX_W'(TAG_N + DIGITS))) w_data = 8'h0D;
      for (int d = 0; d < DIGITS; d++) begin
        if (r_idx == IDX_W'(TAG_N + d)) w_data = {4'h3, r_bcd[(DIGITS-1-d)*4 +: 4]};
      end
`ifdef COUNT_REPORT_MODE_TAG_EN
      if (r_idx == '0) w_data = r_mode ? 8'h44 : 8'h55;
`endif
    end
  end

  assign o_push      = w_push;
  assign o_push_data = w_data;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;

endmodule

// File: tb/tb_count_report_tx.sv
// Directed self-checking bench for count_report_tx; expected frames come from a
// decimal model and are consumed from a scoreboard queue as bytes are pushed.
module tb_count_report_tx;

  localparam int COUNT_W  = 14;
  localparam int DIGITS   = 4;
  localparam int EOL_CRLF = 1;
`ifdef COUNT_REPORT_MODE_TAG_EN
  localparam int TAG_N = 1;
`else
  localparam int TAG_N = 0;
`endif
  localparam int FIRST_PUSH_C = COUNT_W;

  logic               clk;
  logic               reset;
  logic               i_req;
  logic [COUNT_W-1:0] i_count;
  logic               i_mode;
  logic               i_fifo_full;
  logic               o_push;
  logic [7:0]         o_push_data;
  logic               o_busy;
  logic               o_done;

  logic [7:0] exp_q[$];
  int checks;
  int failures;

  count_report_tx #(
    .COUNT_W (COUNT_W),
    .DIGITS  (DIGITS),
    .EOL_CRLF(EOL_CRLF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_req      (i_req),
    .i_count    (i_count),
    .i_mode     (i_mode),
    .i_fifo_full(i_fifo_full),
    .o_push     (o_push),
    .o_push_data(o_push_data),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Decimal model of the frame, independent of the DUT's shift-and-add method.
  task automatic build_exp(input logic [COUNT_W-1:0] cnt, input logic mode);
    int v;
    v = (int'(cnt) > 9999) ? 9999 : int'(cnt);
    exp_q.delete();
    if (TAG_N != 0) exp_q.push_back(mode ? 8'h44 : 8'h55);
    exp_q.push_back(8'(8'h30 + (v / 1000)));
    exp_q.push_back(8'(8'h30 + ((v / 100) % 10)));
    exp_q.push_back(8'(8'h30 + ((v / 10) % 10)));
    exp_q.push_back(8'(8'h30 + (v % 10)));
    if (EOL_CRLF != 0) exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Issue one request and follow the frame to o_done. Cycle c=0 is the cycle
  // right after the request edge. stall_at/poke_at/reset_at < 0 disable.
  task automatic run_frame(input logic [COUNT_W-1:0] cnt, input logic mode,
                           input int stall_at, input int stall_len,
                           input int poke_at, input int reset_at);
    int c, n_push, n_exp, first, last, stall_left;
    bit fin;
    build_exp(cnt, mode);
    n_exp   = exp_q.size();
    i_count = cnt;
    i_mode  = mode;
    i_req   = 1'b1;
    @(posedge clk); #1;
    i_req = 1'b0;
    check("busy_after_req", {31'd0, o_busy}, 32'd1);
    c = 0; n_push = 0; first = -1; last = -1; stall_left = stall_len; fin = 1'b0;
    while (!fin && c < 200) begin
      i_fifo_full = 1'b0;
      if (stall_at >= 0 && n_push == stall_at && stall_left > 0) begin
        i_fifo_full = 1'b1;
        stall_left--;
      end
      if (c == poke_at) begin
        i_req   = 1'b1;
        i_count = 14'd99;
        i_mode  = ~mode;
      end else begin
        i_req = 1'b0;
      end
      if (reset_at >= 0 && n_push == reset_at) begin
        reset = 1'b1;
        #1;
        check("rst_mid_push", {31'd0, o_push}, 32'd0);
        check("rst_mid_busy", {31'd0, o_busy}, 32'd0);
        check("rst_mid_done", {31'd0, o_done}, 32'd0);
        check("rst_mid_data", {24'd0, o_push_data}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        return;
      end
      #1;
      if (i_fifo_full) begin
        check("stall_no_push", {31'd0, o_push}, 32'd0);
        check("stall_data_held", {24'd0, o_push_data}, {24'd0, exp_q[0]});
      end
      if (o_push) begin
        if (first < 0) first = c;
        last = c;
        n_push++;
        if (exp_q.size() == 0) check("frame_len_over", n_push, n_exp);
        else                   check("byte", {24'd0, o_push_data}, {24'd0, exp_q.pop_front()});
      end
      if (o_done) begin
        check("busy_low_at_done", {31'd0, o_busy}, 32'd0);
        fin = 1'b1;
      end
      if (!fin) begin
        @(posedge clk); #1;
        c++;
      end
    end
    i_fifo_full = 1'b0;
    check("done_seen", {31'd0, fin}, 32'd1);
    check("first_push_cycle", first, FIRST_PUSH_C);
    check("push_count", n_push, n_exp);
    check("push_contiguous", last - first, n_exp - 1 + stall_len);
    check("done_after_last", c, last + 1);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      check("idle_no_push", {31'd0, o_push}, 32'd0);
      check("idle_not_busy", {31'd0, o_busy}, 32'd0);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    i_req       = 1'b0;
    i_count     = '0;
    i_mode      = 1'b0;
    i_fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_push", {31'd0, o_push}, 32'd0);
    check("rst_data", {24'd0, o_push_data}, 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_frame(14'd1234, 1'b0, -1, 0, -1, -1);
    // Back-to-back: each request lands in the previous frame's o_done cycle.
    run_frame(14'd0,     1'b0, -1, 0, -1, -1);
    run_frame(14'd16383, 1'b1, -1, 0, -1, -1);
    run_frame(14'd507,   1'b0,  2, 3, -1, -1);
    run_frame(14'd42,    1'b1, -1, 0,  5, -1);
    idle_cycles(3);
    run_frame(14'd1234,  1'b0, -1, 0, -1,  2);
    run_frame(14'd8090,  1'b0, -1, 0, -1, -1);
    run_frame(14'd10000, 1'b1, -1, 0, -1, -1);
    run_frame(14'd9999,  1'b0,  4, 2, -1, -1);
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_report_tx.md
Name: count_report_tx

Overview:
- Encoder counterpart of the UART command decoder.
- On a request pulse, snapshots the 14-bit counter value and converts it to fixed-width decimal ASCII with a sequential binary-to-BCD (double-dabble) engine.
- Pushes the resulting text frame byte-by-byte into the TX FIFO that feeds uart_tx, so the host sees the current count, e.g. "1234\r\n".

Parameters:
- COUNT_W, 14, width of i_count; also the number of double-dabble iterations.
- DIGITS, 4, number of decimal digits emitted; clamp value is 10^DIGITS-1 (9999).
- EOL_CRLF, 1, 1: terminate the frame with 0x0D 0x0A; 0: terminate with 0x0A only.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  report request, sampled only in IDLE; one-cycle pulse expected
- i_count  in  COUNT_W  counter value to report
- i_mode  in  1  counter mode (0 = up, 1 = down); used only with the optional feature
- i_fifo_full  in  1  TX FIFO full flag
- o_push  out  1  TX FIFO push strobe
- o_push_data  out  8  ASCII byte to push
- o_busy  out  1  high while a report is in progress
- o_done  out  1  one-cycle pulse when the frame is completely pushed

Behaviour:
- Clock and reset: clk, rising edge. reset is asynchronous, active-high.
- Reset values: state=IDLE; o_push=0; o_push_data=0x00; o_busy=0; o_done=0; all internal registers cleared.
- States: IDLE -> CONV -> SEND -> IDLE.
- IDLE, i_req=1 at edge N:
  - Latch min(i_count, 10^DIGITS-1) and i_mode.
  - Clear the BCD register, load the iteration counter with COUNT_W, go to CONV.
  - o_busy=1 from edge N.
- CONV:
  - One double-dabble iteration per cycle: add 3 to every BCD nibble >=5, then shift left one bit, pulling in the binary MSB.
  - After exactly COUNT_W iterations (edges N+1..N+COUNT_W), go to SEND with byte index=0.
- SEND:
  - o_push = (state==SEND) && !i_fifo_full, combinational on i_fifo_full.
  - o_push_data = frame[index], driven whenever in SEND.
  - Index advances only on cycles where o_push=1.
  - Frame order: [mode tag if feature enabled], digits most significant first (ASCII 0x30+nibble, leading zeros kept), then EOL.
  - Frame length L = DIGITS + (EOL_CRLF ? 2 : 1) (+1 with feature).
  - On the edge accepting byte L-1: go to IDLE, o_busy=0, o_done=1 for one cycle.
- Latency with no backpressure: first push in the cycle after edge N+COUNT_W; one byte per cycle thereafter.
- Backpressure: while i_fifo_full=1, o_push=0 and o_push_data holds its value. No byte is dropped or duplicated, and a stall of any length is tolerated.
- i_req while busy is ignored; there is no queueing.
- i_count and i_mode changes after the snapshot have no effect on the frame in progress.
- i_req coinciding with the o_done cycle (state is IDLE) starts a new report.
- Overflow: i_count > 9999 clamps to 9999.
- Reset mid-operation: immediate return to IDLE with outputs at reset values. Bytes already pushed remain in the FIFO; no retraction.
- No combinational path from i_req or i_count to the outputs.

Optional Feature:
- Macro: COUNT_REPORT_MODE_TAG_EN.
- Defined: one byte is prepended to the frame, 0x55 ('U') if the latched i_mode=0, 0x44 ('D') if 1. L increases by 1 and the first push is still in the cycle after edge N+COUNT_W.
- Undefined: no tag; i_mode is unused; frame is digits plus EOL only.

Test Plan:
- Count 1234, req pulse, full=0 -> pushes on 6 consecutive cycles: 31 32 33 34 0D 0A. First push 15 cycles after the req edge; o_done pulses once; o_busy falls with o_done.
- Count 0, then count 16383 -> 30 30 30 30 0D 0A, then 39 39 39 39 0D 0A (clamped).
- Count 0507, full held high for 3 cycles when index=2 -> no push for 3 cycles with data held at 0x30; the sequence 30 35 30 37 0D 0A is intact with no duplicates.
- Count 42; second req and count change to 99 during CONV -> only one frame, 30 30 34 32 0D 0A. A req in the o_done cycle starts a new frame.
- reset asserted after 2 bytes pushed -> o_push=0 and o_busy=0 immediately; the next req produces a complete, correct frame.
- With COUNT_REPORT_MODE_TAG_EN, count 42, mode=1 -> 44 30 30 34 32 0D 0A. With EOL_CRLF=0, mode=0 -> 55 30 30 34 32 0A.
